// File: rtl/lab_pio_hub.sv
// lab_pio_hub: Avalon-MM PIO slave for LEDs, slide switches and push-buttons.
// Optional macro PIO_DEBOUNCE_EN adds per-key debounce counters.
module lab_pio_hub #(
   parameter int LED_W           = 8,
   parameter int SW_W            = 8,
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [2:0]       avs_address,
   input  logic             avs_chipselect,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq,
   output logic [LED_W-1:0] led_wire_export,
   input  logic [SW_W-1:0]  switches_wire_export,
   input  logic [KEY_W-1:0] keys_wire_export
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [SW_W-1:0]  sw_s1, sw_s2;
   logic [KEY_W-1:0] key_s1, key_s2;
   logic [KEY_W-1:0] stable, stable_nxt;
   logic [KEY_W-1:0] edge_cap, edge_nxt, mask, w1c;
   logic [31:0]      rd_mux;
   logic             cs_wr, cs_rd;
   logic             unused_bits;

   assign cs_wr = avs_chipselect & avs_write;
   assign cs_rd = avs_chipselect & avs_read;
   assign unused_bits = ^avs_writedata;

   // Two-flop synchronisers; keys are inverted on entry so pressed = 1.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         key_s1 <= '0;
         key_s2 <= '0;
      end else begin
         sw_s1  <= switches_wire_export;
         sw_s2  <= sw_s1;
         key_s1 <= ~keys_wire_export;
         key_s2 <= key_s1;
      end
   end

`ifdef PIO_DEBOUNCE_EN
   logic [CW-1:0] cnt     [KEY_W];
   logic [CW-1:0] cnt_nxt [KEY_W];

   // Accept a new key level only after it has held for DEBOUNCE_CYCLES.
   always_comb begin
      stable_nxt = stable;
      for (int i = 0; i < KEY_W; i++) begin
         cnt_nxt[i] = cnt[i];
         if (key_s2[i] == stable[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_nxt[i] = key_s2[i];
            cnt_nxt[i]    = '0;
         end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
         end
      end
   end

   // Debounce counters and accepted key levels.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         stable <= '0;
         for (int i = 0; i < KEY_W; i++) cnt[i] <= '0;
      end else begin
         stable <= stable_nxt;
         for (int i = 0; i < KEY_W; i++) cnt[i] <= cnt_nxt[i];
      end
   end
`else
   // Without debounce the second synchroniser stage is the stable level.
   assign stable_nxt = key_s1;
   assign stable     = key_s2;
`endif

   assign w1c      = (cs_wr && avs_address == 3'd3) ?
                     avs_writedata[KEY_W-1:0] : '0;
   // A rising stable level beats a same-cycle clear.
   assign edge_nxt = (edge_cap & ~w1c) | (stable_nxt & ~stable);

   // Read mux sees pre-write register values.
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         3'd0:    rd_mux = 32'(sw_s2);
         3'd1:    rd_mux = 32'(stable);
         3'd2:    rd_mux = 32'(led_wire_export);
         3'd3:    rd_mux = 32'(edge_cap);
         3'd4:    rd_mux = 32'(mask);
         default: rd_mux = '0;
      endcase
   end

   // Bus-visible registers, edge capture and registered interrupt.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         led_wire_export <= '0;
         mask            <= '0;
         edge_cap        <= '0;
         irq             <= 1'b0;
         avs_readdata    <= '0;
      end else begin
         edge_cap <= edge_nxt;
         irq      <= |(edge_cap & mask);
         if (cs_rd) avs_readdata <= rd_mux;
         if (cs_wr && avs_address == 3'd2)
            led_wire_export <= avs_writedata[LED_W-1:0];
         if (cs_wr && avs_address == 3'd4)
            mask <= avs_writedata[KEY_W-1:0];
      end
   end

endmodule
